// File: rtl/pixel_write_queue.sv
// Set-pixel / clear-screen write queue: buffers decoder commands, maps (x,y) to a
// linear framebuffer address and issues single-cycle writes around scanout.
module pixel_write_queue #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_pixel_x,
    input  logic [9:0]        i_pixel_y,
    input  logic [11:0]       i_color,
    input  logic              i_set_pixel,
    input  logic              i_fill,
    input  logic [11:0]       i_fill_color,
    input  logic              i_scan_active,
    input  logic              i_clr_flags,
    output logic              o_busy,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [11:0]       o_fb_data,
    output logic              o_overflow,
    output logic              o_dropped
);
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = 20 + ADDR_W;
    localparam int TOTAL = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W:0]   TOTAL_L   = (ADDR_W + 1)'(TOTAL);
    localparam logic [9:0]        FB_W_L    = 10'(FB_W);
    localparam logic [9:0]        FB_H_L    = 10'(FB_H);

    typedef enum logic {RUN, FILL} state_t;
    state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count, count_nxt;
    logic              push, pop;
    logic [31:0]       head;
    logic [LW-1:0]     lin;
    logic              in_range;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [11:0]       a_data;
    logic              b_valid;

    logic              fill_pending;
    logic [11:0]       fill_color;
    logic [ADDR_W:0]   fill_idx;
    logic              fill_more, fill_load, fill_restart;
    logic              b_done, b_free, a_adv, a_free;

    assign push      = i_set_pixel & ~o_busy;
    assign head      = mem[rd_ptr];
    assign lin       = LW'(head[21:12]) * LW'(FB_W) + LW'(head[31:22]);
    assign in_range  = (head[31:22] < FB_W_L) && (head[21:12] < FB_H_L);

    assign b_done    = b_valid & ~i_scan_active;
    assign b_free    = ~b_valid | b_done;
    assign a_adv     = a_valid & b_free;
    assign a_free    = ~a_valid | a_adv;
    // Draining continues while a fill waits: only entries accepted before the
    // fill (busy blocks later ones) can be in the FIFO, and they must go first.
    assign pop       = (count != '0) & a_free & (state == RUN);
    assign count_nxt = count + (PW + 1)'(push) - (PW + 1)'(pop);

    assign fill_more    = (fill_idx != TOTAL_L);
    assign fill_restart = i_fill & (state == FILL);
    assign fill_load    = (state == FILL) & b_free & fill_more & ~i_fill;

    assign o_fb_we = b_valid & ~i_scan_active;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:  if (fill_pending && count == '0 && !a_valid && !b_valid) state_nxt = FILL;
            FILL: if (!i_fill && b_done && o_fb_addr == LAST_ADDR && !fill_more) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_pixel_x, i_pixel_y, i_color};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            a_valid      <= 1'b0;
            a_addr       <= '0;
            a_data       <= '0;
            b_valid      <= 1'b0;
            o_fb_addr    <= '0;
            o_fb_data    <= '0;
            fill_pending <= 1'b0;
            fill_color   <= '0;
            fill_idx     <= '0;
            o_busy       <= 1'b0;
            o_overflow   <= 1'b0;
            o_dropped    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (pop) begin
                a_valid <= in_range;
                a_addr  <= lin[ADDR_W-1:0];
                a_data  <= head[11:0];
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            // A restart abandons the queued fill write and begins again at 0.
            if (fill_restart) begin
                b_valid <= 1'b0;
            end else if (a_adv) begin
                b_valid   <= 1'b1;
                o_fb_addr <= a_addr;
                o_fb_data <= a_data;
            end else if (fill_load) begin
                b_valid   <= 1'b1;
                o_fb_addr <= fill_idx[ADDR_W-1:0];
                o_fb_data <= fill_color;
            end else if (b_done) begin
                b_valid <= 1'b0;
            end

            if (fill_restart || state == RUN) fill_idx <= '0;
            else if (fill_load)               fill_idx <= fill_idx + 1'b1;

            if (i_fill) begin
                fill_pending <= 1'b1;
                fill_color   <= i_fill_color;
            end else if (state == FILL && state_nxt == RUN) begin
                fill_pending <= 1'b0;
            end

            o_busy <= (count_nxt == (PW + 1)'(DEPTH)) | i_fill | fill_pending | (state == FILL);

            if (i_set_pixel && o_busy) o_overflow <= 1'b1;
            else if (i_clr_flags)      o_overflow <= 1'b0;

            if (pop && !in_range)      o_dropped <= 1'b1;
            else if (i_clr_flags)      o_dropped <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: a scoreboard of expected {addr,data}
// writes plus per-scenario latency, flag and busy checks.
module tb_pixel_write_queue;
    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int ADDR_W = 15;
    localparam int W = ADDR_W + 12;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [9:0]        i_pixel_x = '0;
    logic [9:0]        i_pixel_y = '0;
    logic [11:0]       i_color = '0;
    logic              i_set_pixel = 1'b0;
    logic              i_fill = 1'b0;
    logic [11:0]       i_fill_color = '0;
    logic              i_scan_active = 1'b0;
    logic              i_clr_flags = 1'b0;
    logic              o_busy;
    logic              o_fb_we;
    logic [ADDR_W-1:0] o_fb_addr;
    logic [11:0]       o_fb_data;
    logic              o_overflow;
    logic              o_dropped;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    pixel_write_queue #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pixel_x(i_pixel_x), .i_pixel_y(i_pixel_y),
        .i_color(i_color), .i_set_pixel(i_set_pixel), .i_fill(i_fill),
        .i_fill_color(i_fill_color), .i_scan_active(i_scan_active), .i_clr_flags(i_clr_flags),
        .o_busy(o_busy), .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
        .o_overflow(o_overflow), .o_dropped(o_dropped)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard: every issued write must match the oldest expected entry.
    always @(negedge i_clk) begin
        if (i_rst_n && o_fb_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", o_fb_addr, o_fb_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({o_fb_addr, o_fb_data} !== e) begin
                    miscompares++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             o_fb_addr, o_fb_data, e[W-1:12], e[11:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [W-1:0] pix(input int x, input int y, input logic [11:0] c);
        return {ADDR_W'(y * FB_W + x), c};
    endfunction

    task automatic check1(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        vectors++;
        if ({o_fb_we, o_busy, o_overflow, o_dropped} !== 4'b0 || o_fb_addr !== '0 || o_fb_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got we=%b busy=%b ovf=%b drop=%b addr=%0d data=%h, required all 0",
                     o_fb_we, o_busy, o_overflow, o_dropped, o_fb_addr, o_fb_data);
        end
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
        check1("busy_after_reset", o_busy, 1'b0);
    endtask

    task automatic test_single_pixel();
        i_pixel_x = 10'd3; i_pixel_y = 10'd2; i_color = 12'hF00; i_set_pixel = 1'b1;
        exp_q.push_back(pix(3, 2, 12'hF00));
        tick();
        i_set_pixel = 1'b0;
        @(negedge i_clk); check1("single_we_n1", o_fb_we, 1'b0);
        @(negedge i_clk); check1("single_we_n2", o_fb_we, 1'b0);
        @(negedge i_clk); check1("single_we_n3", o_fb_we, 1'b1);
        vectors++;
        if (o_fb_addr !== 15'd323 || o_fb_data !== 12'hF00) begin
            miscompares++;
            $display("FAIL single_addr: got addr=%0d data=%h, required addr=323 data=f00", o_fb_addr, o_fb_data);
        end
        @(negedge i_clk); check1("single_we_n4", o_fb_we, 1'b0);
        wait_drain(10, "single");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            i_pixel_x = 10'(i); i_pixel_y = 10'd0; i_color = 12'(i + 1); i_set_pixel = 1'b1;
            exp_q.push_back(pix(i, 0, 12'(i + 1)));
            tick();
        end
        i_set_pixel = 1'b0;
        while (!o_fb_we && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check1("b2b_first_write", o_fb_we, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk); check1("b2b_consecutive", o_fb_we, 1'b1);
        end
        @(negedge i_clk); check1("b2b_end", o_fb_we, 1'b0);
        check1("b2b_overflow", o_overflow, 1'b0);
        wait_drain(10, "b2b");
    endtask

    task automatic test_stall_full();
        int writes = 0;
        logic [11:0] c;
        i_scan_active = 1'b1;
        // Six entries fit (FIFO of 4 plus stages A and B); strobes 7 and 8 overflow.
        for (int i = 0; i < 8; i++) begin
            c = 12'($urandom_range(0, 4095));
            i_pixel_x = 10'(10 + i); i_pixel_y = 10'd1; i_color = c; i_set_pixel = 1'b1;
            if (i < 6) exp_q.push_back(pix(10 + i, 1, c));
            tick();
        end
        i_set_pixel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_fb_we) writes++;
        end
        vectors++;
        if (writes != 0) begin
            miscompares++;
            $display("FAIL stall_no_write: got %0d writes, required 0", writes);
        end
        check1("stall_busy", o_busy, 1'b1);
        check1("stall_overflow", o_overflow, 1'b1);
        tick();
        i_scan_active = 1'b0;
        wait_drain(30, "stall");
        repeat (2) tick();
        check1("stall_busy_drop", o_busy, 1'b0);
    endtask

    task automatic test_range();
        i_clr_flags = 1'b1;
        tick();
        i_clr_flags = 1'b0;
        check1("ovf_cleared", o_overflow, 1'b0);
        i_pixel_x = 10'd160; i_pixel_y = 10'd0; i_set_pixel = 1'b1;
        tick();
        i_pixel_x = 10'd0; i_pixel_y = 10'd120;
        tick();
        i_set_pixel = 1'b0;
        repeat (8) tick();
        check1("range_dropped", o_dropped, 1'b1);
        i_clr_flags = 1'b1;
        tick();
        i_clr_flags = 1'b0;
        check1("range_cleared", o_dropped, 1'b0);
    endtask

    task automatic test_fill();
        int n = 0;
        i_pixel_x = 10'd5; i_pixel_y = 10'd5; i_color = 12'h123; i_set_pixel = 1'b1;
        i_fill = 1'b1; i_fill_color = 12'h0A5;
        exp_q.push_back(pix(5, 5, 12'h123));
        for (int a = 0; a < FB_W * FB_H; a++) exp_q.push_back({ADDR_W'(a), 12'h0A5});
        tick();
        i_set_pixel = 1'b0; i_fill = 1'b0;
        check1("fill_busy", o_busy, 1'b1);
        while (exp_q.size() != 0 && n < 40000) begin
            @(posedge i_clk);
            n++;
            #1 i_scan_active = (n > 100 && n < 3000) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        i_scan_active = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fill_timeout: got %0d pending writes, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check1("fill_busy_done", o_busy, 1'b0);
        check1("fill_no_drop", o_dropped, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        int n = 0;
        i_fill = 1'b1; i_fill_color = 12'h5A5;
        for (int a = 0; a < FB_W * FB_H; a++) exp_q.push_back({ADDR_W'(a), 12'h5A5});
        tick();
        i_fill = 1'b0;
        while (exp_q.size() > FB_W * FB_H - 100 && n < 500) begin
            @(posedge i_clk);
            n++;
        end
        #2 i_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("rst_we", o_fb_we, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        vectors++;
        if (o_fb_addr !== '0 || o_fb_data !== '0 || o_overflow !== 1'b0 || o_dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_outputs: got addr=%0d data=%h ovf=%b drop=%b, required 0",
                     o_fb_addr, o_fb_data, o_overflow, o_dropped);
        end
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
        i_pixel_x = 10'd7; i_pixel_y = 10'd3; i_color = 12'hABC; i_set_pixel = 1'b1;
        exp_q.push_back(pix(7, 3, 12'hABC));
        tick();
        i_set_pixel = 1'b0;
        wait_drain(10, "post_reset");
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_stall_full();
        test_range();
        test_fill();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
